// File: rtl/alu_branch_resolve.sv
// Branch resolution stage at the consumer end of the ALU result/flag interface.
// Holds the architectural NZCV flags, resolves B/B.cond/CBZ/CBNZ and drives a registered result.

package alu_branch_resolve_pkg;

    typedef enum logic [2:0] {
        ALU_PASS_B = 3'b000,
        ALU_ADD    = 3'b010,
        ALU_SUB    = 3'b011,
        ALU_AND    = 3'b100,
        ALU_OR     = 3'b101,
        ALU_XOR    = 3'b110
    } alu_op_e;

    typedef enum logic [1:0] {
        BR_COND   = 2'b00,
        BR_CBZ    = 2'b01,
        BR_CBNZ   = 2'b10,
        BR_UNCOND = 2'b11
    } br_type_e;

    typedef enum logic [3:0] {
        CC_EQ = 4'b0000,
        CC_NE = 4'b0001,
        CC_CS = 4'b0010,
        CC_CC = 4'b0011,
        CC_MI = 4'b0100,
        CC_PL = 4'b0101,
        CC_VS = 4'b0110,
        CC_VC = 4'b0111,
        CC_HI = 4'b1000,
        CC_LS = 4'b1001,
        CC_GE = 4'b1010,
        CC_LT = 4'b1011,
        CC_GT = 4'b1100,
        CC_LE = 4'b1101,
        CC_AL = 4'b1110,
        CC_NV = 4'b1111
    } cond_e;

    // Flags are packed {N,Z,C,V}, matching the nzcv output.
    function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] f);
        logic n, z, c, v;
        logic hold;
        n = f[3];
        z = f[2];
        c = f[1];
        v = f[0];
        case (cond)
            CC_EQ:   hold = z;
            CC_NE:   hold = !z;
            CC_CS:   hold = c;
            CC_CC:   hold = !c;
            CC_MI:   hold = n;
            CC_PL:   hold = !n;
            CC_VS:   hold = v;
            CC_VC:   hold = !v;
            CC_HI:   hold = c && !z;
            CC_LS:   hold = !(c && !z);
            CC_GE:   hold = (n == v);
            CC_LT:   hold = (n != v);
            CC_GT:   hold = !z && (n == v);
            CC_LE:   hold = !(!z && (n == v));
            default: hold = 1'b1;
        endcase
        return hold;
    endfunction

endpackage

module alu_branch_resolve
    import alu_branch_resolve_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             alu_valid,
    input  logic [2:0]       alu_cntrl,
    input  logic             set_flags,
    input  logic             negative,
    input  logic             zero,
    input  logic             overflow,
    input  logic             carry_out,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [1:0]       br_type,
    input  logic [3:0]       br_cond,
    input  logic             flush,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_taken,
    output logic [3:0]       nzcv,
    output logic [CNT_W-1:0] branch_count,
    output logic [CNT_W-1:0] taken_count
);

    logic [3:0]       nzcv_q, nzcv_d;
    logic             res_valid_q, res_valid_d;
    logic             res_taken_q, res_taken_d;
    logic [CNT_W-1:0] branch_count_q, branch_count_d;
    logic [CNT_W-1:0] taken_count_q, taken_count_d;

    logic capture;
    logic arith_op;
    logic is_cb;
    logic accept;
    logic taken_eval;

    assign capture  = alu_valid && set_flags;
    assign arith_op = (alu_cntrl == ALU_ADD) || (alu_cntrl == ALU_SUB);
    assign is_cb    = (br_type == BR_CBZ) || (br_type == BR_CBNZ);

    // NOTE: every signal written in an always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nzcv_d = nzcv_q;
        if (capture) begin
            nzcv_d[3] = negative;
            nzcv_d[2] = zero;
            if (arith_op) begin
                nzcv_d[1] = carry_out;
                nzcv_d[0] = overflow;
            end
        end
    end

    // nzcv_d already equals nzcv_q when nothing is captured, so it doubles as the forwarded flag set.
    always_comb begin
        taken_eval = 1'b1;
        case (br_type)
            BR_COND:   taken_eval = cond_holds(br_cond, nzcv_d);
            BR_CBZ:    taken_eval = zero;
            BR_CBNZ:   taken_eval = !zero;
            BR_UNCOND: taken_eval = 1'b1;
            default:   taken_eval = 1'b1;
        endcase
    end

    assign br_ready = !(res_valid_q && !res_ready) && !(is_cb && !alu_valid) && !flush;
    assign accept   = br_valid && br_ready;

    always_comb begin
        res_valid_d    = res_valid_q;
        res_taken_d    = res_taken_q;
        branch_count_d = branch_count_q;
        taken_count_d  = taken_count_q;

        if (flush) begin
            res_valid_d = 1'b0;
        end else if (accept) begin
            res_valid_d = 1'b1;
            res_taken_d = taken_eval;
        end else if (res_valid_q && res_ready) begin
            res_valid_d = 1'b0;
        end

        // Counters stick at all-ones rather than wrapping.
        if (accept) begin
            if (!(&branch_count_q)) begin
                branch_count_d = branch_count_q + CNT_W'(1);
            end
            if (taken_eval && !(&taken_count_q)) begin
                taken_count_d = taken_count_q + CNT_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            nzcv_q         <= 4'b0000;
            res_valid_q    <= 1'b0;
            res_taken_q    <= 1'b0;
            branch_count_q <= '0;
            taken_count_q  <= '0;
        end else begin
            nzcv_q         <= nzcv_d;
            res_valid_q    <= res_valid_d;
            res_taken_q    <= res_taken_d;
            branch_count_q <= branch_count_d;
            taken_count_q  <= taken_count_d;
        end
    end

    assign nzcv         = nzcv_q;
    assign res_valid    = res_valid_q;
    assign res_taken    = res_taken_q;
    assign branch_count = branch_count_q;
    assign taken_count  = taken_count_q;

endmodule

// File: tb/tb_alu_branch_resolve.sv
// Directed bench for alu_branch_resolve: flags, forwarding, CBZ stall, backpressure, flush,
// counter saturation (CNT_W=4) and asynchronous reset.

module tb_alu_branch_resolve;

    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             alu_valid;
    logic [2:0]       alu_cntrl;
    logic             set_flags;
    logic             negative, zero, overflow, carry_out;
    logic             br_valid;
    logic             br_ready;
    logic [1:0]       br_type;
    logic [3:0]       br_cond;
    logic             flush;
    logic             res_valid;
    logic             res_ready;
    logic             res_taken;
    logic [3:0]       nzcv;
    logic [CNT_W-1:0] branch_count;
    logic [CNT_W-1:0] taken_count;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_bc   = 0;
    int exp_tc   = 0;

    alu_branch_resolve #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .alu_valid    (alu_valid),
        .alu_cntrl    (alu_cntrl),
        .set_flags    (set_flags),
        .negative     (negative),
        .zero         (zero),
        .overflow     (overflow),
        .carry_out    (carry_out),
        .br_valid     (br_valid),
        .br_ready     (br_ready),
        .br_type      (br_type),
        .br_cond      (br_cond),
        .flush        (flush),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_taken    (res_taken),
        .nzcv         (nzcv),
        .branch_count (branch_count),
        .taken_count  (taken_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; outputs are sampled there or 1 unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        alu_valid = 1'b0; alu_cntrl = 3'b000; set_flags = 1'b0;
        negative  = 1'b0; zero = 1'b0; overflow = 1'b0; carry_out = 1'b0;
        br_valid  = 1'b0; br_type = 2'b11; br_cond = 4'b0000;
        flush     = 1'b0; res_ready = 1'b1;
    endtask

    task automatic alu_op(input logic [2:0] op, input logic n, input logic z,
                          input logic c, input logic v);
        alu_valid = 1'b1; set_flags = 1'b1; alu_cntrl = op;
        negative = n; zero = z; carry_out = c; overflow = v;
    endtask

    task automatic alu_off();
        alu_valid = 1'b0; set_flags = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        idle();
        #12;
        n_checks++;
        if ({nzcv, res_valid, res_taken} !== 6'b0) begin
            n_fail++; $display("FAIL reset_state: nzcv/valid/taken=%b required 000000", {nzcv, res_valid, res_taken});
        end
        n_checks++;
        if (branch_count !== 4'd0 || taken_count !== 4'd0) begin
            n_fail++; $display("FAIL reset_counters: bc=%0d tc=%0d required 0/0", branch_count, taken_count);
        end
        step();
        reset_n = 1'b1;
        step();
        #1;
        n_checks++;
        if (br_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_br_ready: got %b required 1", br_ready);
        end
    endtask

    task automatic test_flags_eq();
        alu_op(3'b011, 1'b0, 1'b1, 1'b1, 1'b0);
        step();
        alu_off();
        n_checks++;
        if (nzcv !== 4'b0110) begin
            n_fail++; $display("FAIL subs_nzcv: got %b required 0110", nzcv);
        end
        br_valid = 1'b1; br_type = 2'b00; br_cond = 4'b0000;
        step();
        br_valid = 1'b0;
        exp_bc++; exp_tc++;
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
            n_fail++; $display("FAIL eq_result: valid=%b taken=%b required 1/1", res_valid, res_taken);
        end
        n_checks++;
        if (branch_count !== 4'(exp_bc) || taken_count !== 4'(exp_tc)) begin
            n_fail++; $display("FAIL eq_counters: bc=%0d tc=%0d required %0d/%0d", branch_count, taken_count, exp_bc, exp_tc);
        end
        step();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL eq_drain: res_valid=%b required 0", res_valid);
        end
    endtask

    task automatic test_forwarding();
        // Each case clears nzcv first, then issues SUBS(N=1,V=0) and the branch together.
        for (int k = 0; k < 2; k++) begin
            alu_op(3'b011, 1'b0, 1'b0, 1'b0, 1'b0);
            step();
            n_checks++;
            if (nzcv !== 4'b0000) begin
                n_fail++; $display("FAIL fwd_clear_%0d: nzcv=%b required 0000", k, nzcv);
            end
            alu_op(3'b011, 1'b1, 1'b0, 1'b0, 1'b0);
            br_valid = 1'b1; br_type = 2'b00;
            br_cond  = (k == 0) ? 4'b1011 : 4'b1010;
            step();
            alu_off(); br_valid = 1'b0;
            exp_bc++;
            if (k == 0) exp_tc++;
            n_checks++;
            if (res_valid !== 1'b1 || res_taken !== (k == 0)) begin
                n_fail++; $display("FAIL fwd_%s: valid=%b taken=%b required 1/%0d", (k == 0) ? "lt" : "ge", res_valid, res_taken, (k == 0));
            end
        end
        n_checks++;
        if (nzcv !== 4'b1000) begin
            n_fail++; $display("FAIL fwd_nzcv: got %b required 1000", nzcv);
        end
        step();
    endtask

    task automatic test_logical_preserve();
        alu_op(3'b011, 1'b0, 1'b0, 1'b1, 1'b1);
        step();
        n_checks++;
        if (nzcv !== 4'b0011) begin
            n_fail++; $display("FAIL preset_nzcv: got %b required 0011", nzcv);
        end
        alu_op(3'b100, 1'b0, 1'b1, 1'b0, 1'b0);
        step();
        alu_off();
        n_checks++;
        if (nzcv !== 4'b0111) begin
            n_fail++; $display("FAIL ands_nzcv: got %b required 0111", nzcv);
        end
        // Flags-less ALU activity must leave nzcv alone.
        alu_valid = 1'b1; alu_cntrl = 3'b010; negative = 1'b1; zero = 1'b0;
        step();
        alu_off();
        n_checks++;
        if (nzcv !== 4'b0111) begin
            n_fail++; $display("FAIL noset_hold: got %b required 0111", nzcv);
        end
    endtask

    task automatic test_cbz_stall();
        br_valid = 1'b1; br_type = 2'b01; alu_valid = 1'b0; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (br_ready !== 1'b0) begin
                n_fail++; $display("FAIL cbz_stall_%0d: br_ready=%b required 0", i, br_ready);
            end
            step();
        end
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL cbz_no_result: res_valid=%b required 0", res_valid);
        end
        alu_valid = 1'b1;
        #1;
        n_checks++;
        if (br_ready !== 1'b1) begin
            n_fail++; $display("FAIL cbz_ready: br_ready=%b required 1", br_ready);
        end
        step();
        exp_bc++; exp_tc++;
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b1) begin
            n_fail++; $display("FAIL cbz_taken: valid=%b taken=%b required 1/1", res_valid, res_taken);
        end
        br_type = 2'b10;
        step();
        exp_bc++;
        n_checks++;
        if (res_valid !== 1'b1 || res_taken !== 1'b0) begin
            n_fail++; $display("FAIL cbnz_not_taken: valid=%b taken=%b required 1/0", res_valid, res_taken);
        end
        br_valid = 1'b0; alu_valid = 1'b0; zero = 1'b0;
        n_checks++;
        if (branch_count !== 4'(exp_bc) || taken_count !== 4'(exp_tc)) begin
            n_fail++; $display("FAIL cbz_counters: bc=%0d tc=%0d required %0d/%0d", branch_count, taken_count, exp_bc, exp_tc);
        end
        step();
    endtask

    task automatic test_backpressure_flush();
        // nzcv is 0111 here, so NE resolves not-taken; a taken B then waits behind it.
        res_ready = 1'b0;
        br_valid = 1'b1; br_type = 2'b00; br_cond = 4'b0001;
        step();
        exp_bc++;
        br_type = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_checks++;
            if (br_ready !== 1'b0 || res_valid !== 1'b1 || res_taken !== 1'b0) begin
                n_fail++; $display("FAIL hold_%0d: ready=%b valid=%b taken=%b required 0/1/0", i, br_ready, res_valid, res_taken);
            end
            step();
        end
        n_checks++;
        if (branch_count !== 4'(exp_bc) || taken_count !== 4'(exp_tc)) begin
            n_fail++; $display("FAIL hold_counters: bc=%0d tc=%0d required %0d/%0d", branch_count, taken_count, exp_bc, exp_tc);
        end
        res_ready = 1'b1;
        flush = 1'b1;
        alu_op(3'b000, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        n_checks++;
        if (br_ready !== 1'b0) begin
            n_fail++; $display("FAIL flush_ready: br_ready=%b required 0", br_ready);
        end
        step();
        flush = 1'b0; br_valid = 1'b0; alu_off();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL flush_valid: res_valid=%b required 0", res_valid);
        end
        n_checks++;
        if (branch_count !== 4'(exp_bc)) begin
            n_fail++; $display("FAIL flush_count: bc=%0d required %0d", branch_count, exp_bc);
        end
        n_checks++;
        if (nzcv !== 4'b1011) begin
            n_fail++; $display("FAIL flush_nzcv: got %b required 1011", nzcv);
        end
    endtask

    task automatic test_saturation();
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        exp_bc = 0; exp_tc = 0;
        step();
        br_valid = 1'b1; br_type = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            step();
            if (exp_bc < 15) exp_bc++;
            if (exp_tc < 15) exp_tc++;
            if (i == 10) begin
                n_checks++;
                if (branch_count !== 4'd10 || taken_count !== 4'd10) begin
                    n_fail++; $display("FAIL count_10: bc=%0d tc=%0d required 10/10", branch_count, taken_count);
                end
            end
        end
        br_valid = 1'b0;
        n_checks++;
        if (branch_count !== 4'(exp_bc) || taken_count !== 4'(exp_tc) || exp_bc != 15) begin
            n_fail++; $display("FAIL saturate: bc=%0d tc=%0d required 15/15", branch_count, taken_count);
        end
        step();
    endtask

    task automatic test_async_reset();
        res_ready = 1'b0;
        alu_op(3'b010, 1'b1, 1'b1, 1'b1, 1'b1);
        br_valid = 1'b1; br_type = 2'b11;
        step();
        br_valid = 1'b0; alu_off();
        n_checks++;
        if (res_valid !== 1'b1 || nzcv !== 4'b1111) begin
            n_fail++; $display("FAIL pre_reset: valid=%b nzcv=%b required 1/1111", res_valid, nzcv);
        end
        #2;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if ({nzcv, res_valid, res_taken} !== 6'b0 || branch_count !== 4'd0 || taken_count !== 4'd0) begin
            n_fail++; $display("FAIL async_reset: nzcv=%b valid=%b taken=%b bc=%0d tc=%0d required all 0",
                               nzcv, res_valid, res_taken, branch_count, taken_count);
        end
        step();
        reset_n = 1'b1;
        res_ready = 1'b1;
        step();
        n_checks++;
        if (res_valid !== 1'b0) begin
            n_fail++; $display("FAIL post_reset_valid: res_valid=%b required 0", res_valid);
        end
    endtask

    initial begin
        test_reset();
        test_flags_eq();
        test_forwarding();
        test_logical_preserve();
        test_cbz_stall();
        test_backpressure_flush();
        test_saturation();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_branch_resolve.md
Name: alu_branch_resolve

Overview:
- Consumer end of the 64-bit ALU result/flag interface. Captures ALU flags into an architectural NZCV register when flag-setting ops complete.
- Resolves B, B.cond, CBZ and CBNZ requests against those flags or against the same-cycle ALU zero output.
- Result path is a registered valid/ready stage feeding the fetch/PC-select logic.
- Carries saturating branch and taken counters for performance debug.

Parameters:
- CNT_W, 16, width of the saturating branch_count and taken_count counters.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset_n  input  1  asynchronous active-low reset.
- alu_valid  input  1  ALU outputs are valid this cycle.
- alu_cntrl  input  3  ALU op: 000 pass B, 010 add, 011 sub, 100 and, 101 or, 110 xor.
- set_flags  input  1  op is flag-setting (ADDS/SUBS/ANDS class).
- negative, zero, overflow, carry_out  input  1 each  ALU flag outputs.
- br_valid  input  1  branch request present.
- br_ready  output  1  request accepted this cycle when br_valid && br_ready.
- br_type  input  2  00 B.cond, 01 CBZ, 10 CBNZ, 11 unconditional B.
- br_cond  input  4  ARM condition code, used for B.cond only.
- flush  input  1  synchronous kill of any held result.
- res_valid  output  1  resolved branch available.
- res_ready  input  1  downstream accepts result.
- res_taken  output  1  branch taken.
- nzcv  output  4  architectural flags {N,Z,C,V}.
- branch_count  output  CNT_W  resolved branches, saturating.
- taken_count  output  CNT_W  taken branches, saturating.

Behaviour:
- Reset (reset_n low, asynchronous): nzcv=0000, res_valid=0, res_taken=0, both counters=0. br_ready is combinational and follows the rules below from the first cycle after release.
- Flag capture: on an edge with alu_valid && set_flags, N<=negative and Z<=zero.
  - C<=carry_out and V<=overflow only when alu_cntrl is 010 or 011.
  - For other alu_cntrl values C and V keep their prior values.
  - Without alu_valid && set_flags, nzcv holds.
- Condition evaluation for B.cond, using effective flags F:
  - F = the updated flags per the capture rule if alu_valid && set_flags this cycle (forwarding); otherwise F = nzcv.
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !(C&!Z); 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE !(!Z&(N==V)).
  - 1110 and 1111 always taken.
- CBZ/CBNZ: taken = zero (CBZ) or !zero (CBNZ), sampled from the ALU in the same cycle. They require alu_valid; if alu_valid=0, br_ready=0 (stall).
- Unconditional B: always taken, never stalls on the ALU.
- br_ready = !(res_valid && !res_ready) && !(br_type in {01,10} && !alu_valid) && !flush.
- On accept (br_valid && br_ready), next edge: res_valid<=1, res_taken<=evaluated value. Latency is exactly 1 cycle from accept to res_valid.
- Result hold: while res_valid && !res_ready, res_valid and res_taken are held stable.
- Result drain: res_valid clears on res_valid && res_ready unless a new accept occurs the same edge. Back-to-back throughput is one branch per cycle when res_ready=1.
- Flush: on an edge with flush=1, res_valid<=0. br_ready=0 that cycle, so no accept. nzcv capture still occurs (flags are architectural); counters do not increment.
- Counters: on each accept, branch_count+=1 and taken_count+=1 if taken. Both saturate at all-ones with no wrap.
- A reset assertion mid-operation clears any held result immediately; it is not delivered.

Test Plan:
- SUBS A=5,B=5 (alu_cntrl=011, set_flags=1, zero=1, carry_out=1) → nzcv=0110 after the edge. Then B.cond EQ (0000) → res_valid=1 and res_taken=1 one cycle after accept.
- Forwarding: same-cycle SUBS producing N=1,V=0 plus B.cond LT (1011), with nzcv previously 0000 → res_taken=1. A B.cond GE issued instead → res_taken=0.
- Logical op preserves C/V: nzcv=0011, then ANDS with result 0 (alu_cntrl=100, zero=1, carry_out=0, overflow=0) → nzcv=0111.
- CBZ with alu_valid=0 → br_ready=0 for 3 cycles. Assert alu_valid with zero=1 → accept, res_taken=1. CBNZ with zero=1 → res_taken=0.
- Backpressure/flush: res_ready=0 with res_valid=1 → br_ready=0 and res_taken stable for 4 cycles. Assert flush → res_valid=0 next cycle; branch_count unchanged.
- Saturation and reset: CNT_W=4, issue 20 unconditional B → branch_count=taken_count=15. Pulse reset_n low mid-transfer → all outputs 0 asynchronously.
